// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares one single-port word RAM between the instruction-fetch port and the
// load/store data port. The RAM reads asynchronously and writes on the rising
// clock edge. Each port uses a req/ack handshake. The arbiter works in three
// steps:
//   1. It latches the winning request on the grant edge.
//   2. It drives the RAM for exactly one cycle.
//   3. It returns registered read data with a one-cycle ack pulse.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   -> round-robin tie break. A last-grant register is kept, and
//                the first tie after reset goes to fetch.
//   undefined -> fixed priority. Data wins every tie.
//
// Ports:
//   clk, resetN        rising-edge clock, synchronous active-low reset
//   ifReq/ifAddr       fetch request and word address
//   ifRdata/ifAck/ifErr  fetch read data, completion pulse, out-of-range flag
//   dReq/dWe/dAddr/dWdata  data request, store enable, word address, store data
//   dRdata/dAck/dErr   load data (0 for stores), completion pulse, range flag
//   memAddr/memWe/memDin   RAM address, write enable, write data
//   memDout            RAM combinational read data
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic [31:0] ifRdata,
  output logic        ifAck,
  output logic        ifErr,
  input  logic        dReq,
  input  logic        dWe,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        dAck,
  output logic        dErr,
  output logic [31:0] memAddr,
  output logic        memWe,
  output logic [31:0] memDin,
  input  logic [31:0] memDout
);

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_D} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        mem_we_q;
  logic        if_ack_q, d_ack_q;
  logic        if_err_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  // An address is in range when every bit above the RAM index field is zero.
  function automatic logic addr_in_range(input logic [31:0] a);
    return a[31:DEPTH_LOG2] == '0;
  endfunction

  // A port cannot win in the cycle its own ack is high. Otherwise a req that
  // is still held would be granted twice.
  logic if_elig, d_elig, grant_data, grant_fetch, in_range;
  assign if_elig  = ifReq & ~if_ack_q;
  assign d_elig   = dReq  & ~d_ack_q;
  assign in_range = addr_in_range(addr_q);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data_q;  // 1 = data was granted last
  // On a tie, data wins only if fetch was granted last.
  assign grant_data = d_elig & (~if_elig | ~last_data_q);
`else
  assign grant_data = d_elig;
`endif
  assign grant_fetch = if_elig & ~grant_data;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_err_q   <= 1'b0;
      d_err_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments, so every right-hand
      // side sees pre-edge values and this default is overridden within the block.
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_data) begin
            state_q  <= SERVE_D;
            addr_q   <= dAddr;
            we_q     <= dWe;
            wdata_q  <= dWdata;
            mem_we_q <= dWe & addr_in_range(dAddr);
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b1;
`endif
          end else if (grant_fetch) begin
            state_q  <= SERVE_IF;
            addr_q   <= ifAddr;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b0;
`endif
          end
        end
        SERVE_IF: begin
          if_rdata_q <= in_range ? memDout : '0;
          if_err_q   <= ~in_range;
          if_ack_q   <= 1'b1;
          state_q    <= IDLE;
        end
        SERVE_D: begin
          d_rdata_q <= (!we_q && in_range) ? memDout : '0;
          d_err_q   <= ~in_range;
          d_ack_q   <= 1'b1;
          mem_we_q  <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // memAddr and memDin come straight from the latch registers, so they keep
  // their last granted values outside the serve cycle.
  assign memAddr = addr_q;
  assign memDin  = wdata_q;
  assign memWe   = mem_we_q;
  assign ifRdata = if_rdata_q;
  assign ifAck   = if_ack_q;
  assign ifErr   = if_err_q;
  assign dRdata  = d_rdata_q;
  assign dAck    = d_ack_q;
  assign dErr    = d_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed bench for memory_arbiter. It contains a behavioural 1024-word RAM
// with an asynchronous read and a write on the rising edge. Expected values are
// hand-computed from the RAM preload: word i holds 0xA0000000 | i, and word 5
// holds 0xDEADBEEF.
//
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        resetN;
  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata;
  logic [31:0] ifRdata, dRdata, memAddr, memDin, memDout;
  logic        ifAck, ifErr, dAck, dErr, memWe;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ram [0:1023];
  logic        preload;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA000_0000 | 32'(i);
      ram[5] <= 32'hDEAD_BEEF;
    end else if (memWe) begin
      ram[memAddr[9:0]] <= memDin;
    end
  end
  assign memDout = ram[memAddr[9:0]];

  memory_arbiter #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .resetN(resetN),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifRdata(ifRdata), .ifAck(ifAck), .ifErr(ifErr),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(dRdata), .dAck(dAck), .dErr(dErr),
    .memAddr(memAddr), .memWe(memWe), .memDin(memDin), .memDout(memDout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ifAck"},   32'(ifAck),   32'd0);
    check({tag, "_dAck"},    32'(dAck),    32'd0);
    check({tag, "_ifErr"},   32'(ifErr),   32'd0);
    check({tag, "_dErr"},    32'(dErr),    32'd0);
    check({tag, "_ifRdata"}, ifRdata,      32'd0);
    check({tag, "_dRdata"},  dRdata,       32'd0);
    check({tag, "_memAddr"}, memAddr,      32'd0);
    check({tag, "_memDin"},  memDin,       32'd0);
    check({tag, "_memWe"},   32'(memWe),   32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_if, exp_d;
    resetN = 1'b0; preload = 1'b1;
    ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    tick(); tick();
    preload = 1'b0;
    check_reset_state("rst");
    resetN = 1'b1;
    tick();

    // Fetch from word 5. The req drops after the grant, but the access still completes.
    ifReq = 1'b1; ifAddr = 32'd5;
    tick();
    check("rd_grant_memAddr", memAddr, 32'd5);
    check("rd_grant_memWe", 32'(memWe), 32'd0);
    check("rd_grant_ifAck", 32'(ifAck), 32'd0);
    ifReq = 1'b0; ifAddr = 32'd99;
    tick();
    check("rd_ifAck", 32'(ifAck), 32'd1);
    check("rd_ifRdata", ifRdata, 32'hDEAD_BEEF);
    check("rd_ifErr", 32'(ifErr), 32'd0);
    check("rd_memWe", 32'(memWe), 32'd0);
    tick();
    check("rd_ifAck_drop", 32'(ifAck), 32'd0);

    // Store to the top word, then load it back. Inputs change after the grant.
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h3FF; dWdata = 32'h1234_5678;
    tick();
    dReq = 1'b0; dAddr = 32'd0; dWdata = 32'd0;
    check("st_memWe", 32'(memWe), 32'd1);
    check("st_memAddr", memAddr, 32'h3FF);
    check("st_memDin", memDin, 32'h1234_5678);
    tick();
    check("st_dAck", 32'(dAck), 32'd1);
    check("st_dRdata", dRdata, 32'd0);
    check("st_dErr", 32'(dErr), 32'd0);
    check("st_memWe_drop", 32'(memWe), 32'd0);
    check("st_ram", ram[10'h3FF], 32'h1234_5678);
    tick();
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h3FF;
    tick();
    dReq = 1'b0;
    check("ld_memWe", 32'(memWe), 32'd0);
    tick();
    check("ld_dAck", 32'(dAck), 32'd1);
    check("ld_dRdata", dRdata, 32'h1234_5678);
    tick();

    // Out-of-range store and load.
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h400; dWdata = 32'hFFFF_FFFF;
    tick();
    dReq = 1'b0;
    check("oor_st_memWe", 32'(memWe), 32'd0);
    tick();
    check("oor_st_dAck", 32'(dAck), 32'd1);
    check("oor_st_dErr", 32'(dErr), 32'd1);
    check("oor_st_dRdata", dRdata, 32'd0);
    check("oor_st_ram0", ram[0], 32'hA000_0000);
    tick();
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h400;
    tick();
    dReq = 1'b0;
    tick();
    check("oor_ld_dAck", 32'(dAck), 32'd1);
    check("oor_ld_dErr", 32'(dErr), 32'd1);
    check("oor_ld_dRdata", dRdata, 32'd0);
    tick();

    // With fetch req held for 10 cycles, acks appear after ticks 2, 5 and 8 only.
    ifReq = 1'b1; ifAddr = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("held_ifAck_c%0d", k), 32'(ifAck),
            32'((k == 2) || (k == 5) || (k == 8)));
      if (k == 2) check("held_ifRdata", ifRdata, 32'hA000_0007);
    end
    ifReq = 1'b0;
    tick(); tick(); tick();

    // Fresh reset, then both ports held. Each port's ack cycle hands the next
    // slot to the other port. Only the first grant is a real tie.
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    ifReq = 1'b1; ifAddr = 32'd9; dReq = 1'b1; dWe = 1'b0; dAddr = 32'd10;
    for (int k = 1; k <= 12; k++) begin
      tick();
`ifdef ARB_ROUND_ROBIN_EN
      exp_if = (k % 4 == 2);
      exp_d  = (k % 4 == 0);
`else
      exp_d  = (k % 4 == 2);
      exp_if = (k % 4 == 0);
`endif
      check($sformatf("tie_ifAck_c%0d", k), 32'(ifAck), 32'(exp_if));
      check($sformatf("tie_dAck_c%0d", k), 32'(dAck), 32'(exp_d));
      if (exp_if) check("tie_ifRdata", ifRdata, 32'hA000_0009);
      if (exp_d)  check("tie_dRdata", dRdata, 32'hA000_000A);
    end
    ifReq = 1'b0; dReq = 1'b0;
    tick(); tick(); tick();

    // Reset asserted during SERVE_D of a store: the RAM still takes the write, and no ack is given.
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h20; dWdata = 32'hCAFE_F00D;
    tick();
    check("rst_st_memWe", 32'(memWe), 32'd1);
    resetN = 1'b0; dReq = 1'b0;
    tick();
    check_reset_state("mid_rst");
    resetN = 1'b1;
    tick();
    check("mid_rst_dAck", 32'(dAck), 32'd0);
    check("mid_rst_ram", ram[10'h20], 32'hCAFE_F00D);
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h20;
    tick();
    dReq = 1'b0;
    tick();
    check("post_rst_dAck", 32'(dAck), 32'd1);
    check("post_rst_dRdata", dRdata, 32'hCAFE_F00D);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
